color_classifier: RTL and testbench

Parametrised successor to the path sensor's color front end. It sequences the four filters of a TCS3200-class light-to-frequency sensor, applying a settle blanking window after each filter switch. It counts sensor output edges over a programmable gate window and scales each channel by a runtime gain. It then classifies the dominant color, with N-round confirmation before the reported color changes, so the path FSM (start/slow/stop) sees a debounced, validated color code.

---
 rtl/color_pkg.sv | 42 ++++
 rtl/color_classifier_edge_counter.sv | 57 +++++
 rtl/color_classifier.sv | 206 ++++++++++++++++++++
 tb/tb_color_classifier.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and constants for the colour classifier: filter indices,
// FSM states, S2/S3 filter-select codes and the reported colour codes.
package color_pkg;

    // Filter index; doubles as the channel slot in the packed gain/counts buses.
    typedef enum logic [1:0] {
        FILT_BLUE  = 2'd0,
        FILT_GREEN = 2'd1,
        FILT_RED   = 2'd2,
        FILT_CLEAR = 2'd3
    } filter_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DECIDE
    } state_t;

    // Filter select codes, packed as {S2, S3}.
    localparam logic [1:0] SEL_BLUE  = 2'b01;
    localparam logic [1:0] SEL_GREEN = 2'b11;
    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_CLEAR = 2'b10;

    // Colour codes seen by the path FSM.
    localparam logic [2:0] COLOR_NONE  = 3'd0;
    localparam logic [2:0] COLOR_RED   = 3'd1;
    localparam logic [2:0] COLOR_GREEN = 3'd2;
    localparam logic [2:0] COLOR_BLUE  = 3'd3;
    localparam logic [2:0] COLOR_CLEAR = 3'd4;

    function automatic logic [1:0] filter_select(input filter_t f);
        case (f)
            FILT_BLUE:  return SEL_BLUE;
            FILT_GREEN: return SEL_GREEN;
            FILT_RED:   return SEL_RED;
            default:    return SEL_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/color_classifier_edge_counter.sv
// Synchronises the sensor output, detects rising edges and counts them in a
// saturating counter. count_next already includes an edge seen this cycle so
// the caller can latch a window's result on its final cycle.
module edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             signal_in,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sync_a;
    logic             sync_b;
    logic             last;
    logic             rise;
    logic [CNT_W-1:0] count;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            last   <= 1'b0;
        end else begin
            sync_a <= signal_in;
            sync_b <= sync_a;
            last   <= sync_b;
        end
    end

    assign rise = sync_b & ~last;

    // Next count: cleared, incremented on an enabled edge, or held at saturation.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (count_en && rise && (count != CNT_MAX)) begin
            count_next = count + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/color_classifier.sv
// Sequences the four sensor filters, measures each over a gate window,
// applies per-channel gains, picks the dominant colour and only reports it
// once it has been seen CONFIRM rounds in a row.
module color_classifier
    import color_pkg::*;
#(
    parameter int GATE_CYCLES   = 6250000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int GAIN_W        = 6,
    parameter int CONFIRM       = 3,
    parameter bit SCALE_S0      = 1'b1,
    parameter bit SCALE_S1      = 1'b0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                colorsignal,
    input  logic [4*GAIN_W-1:0] gain,
    output logic                S0,
    output logic                S1,
    output logic                S2,
    output logic                S3,
    output logic [4*CNT_W-1:0]  counts,
    output logic                raw_valid,
    output logic [2:0]          raw_color,
    output logic [2:0]          color,
    output logic                color_changed
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PROD_W  = CNT_W + GAIN_W;
    localparam int CONF_W  = $clog2(CONFIRM + 1);

    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_MAX    = CONF_W'(CONFIRM);

    state_t            state;
    state_t            state_next;
    filter_t           idx;
    filter_t           idx_next;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;
    logic [1:0]        sel;
    logic              cnt_clear;
    logic              cnt_en;
    logic              last_gate;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  chan_cnt [4];
    logic [PROD_W-1:0] scaled [4];
    logic [2:0]        decision;
    logic [2:0]        candidate;
    logic [2:0]        cand_next;
    logic [CONF_W-1:0] confirm_cnt;
    logic [CONF_W-1:0] conf_next;
    logic              update;

    assign S0 = SCALE_S0;
    assign S1 = SCALE_S1;

    edge_counter #(
        .CNT_W(CNT_W)
    ) u_edge_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .signal_in  (colorsignal),
        .clear      (cnt_clear),
        .count_en   (cnt_en),
        .count_next (cnt_next)
    );

    // FSM state, current filter and phase timer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= FILT_BLUE;
            timer <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            timer <= timer_next;
        end
    end

    // Next-state logic; dropping enable abandons the round immediately.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        timer_next = timer + 1'b1;
        case (state)
            ST_IDLE: begin
                timer_next = '0;
                idx_next   = FILT_BLUE;
                if (enable) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else if (timer == SETTLE_LAST) begin
                    state_next = ST_GATE;
                    timer_next = '0;
                end
            end
            ST_GATE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end else if (timer == GATE_LAST) begin
                    timer_next = '0;
                    if (idx == FILT_CLEAR) begin
                        state_next = ST_DECIDE;
                    end else begin
                        state_next = ST_SETTLE;
                        idx_next   = filter_t'(idx + 2'd1);
                    end
                end
            end
            default: begin
                timer_next = '0;
                idx_next   = FILT_BLUE;
                state_next = enable ? ST_SETTLE : ST_IDLE;
            end
        endcase
    end

    // Filter select and counter control; the counter is held clear outside GATE.
    always_comb begin
        sel       = SEL_BLUE;
        if (state != ST_IDLE) sel = filter_select(idx);
        cnt_clear = (state != ST_GATE);
        cnt_en    = (state == ST_GATE);
        last_gate = (state == ST_GATE) && enable && (timer == GATE_LAST);
    end

    assign S2 = sel[1];
    assign S3 = sel[0];

    // Per-channel counts of the round in progress, latched at each gate end.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) chan_cnt[i] <= '0;
        end else if (last_gate) begin
            chan_cnt[idx] <= cnt_next;
        end
    end

    // Gain scaling and strict-dominance classification; ties fall to CLEAR.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            scaled[i] = PROD_W'(chan_cnt[i]) * PROD_W'(gain[i*GAIN_W +: GAIN_W]);
        end
        decision = COLOR_CLEAR;
        if (scaled[FILT_RED] > scaled[FILT_GREEN] && scaled[FILT_RED] > scaled[FILT_BLUE] &&
            scaled[FILT_RED] > scaled[FILT_CLEAR]) begin
            decision = COLOR_RED;
        end else if (scaled[FILT_GREEN] > scaled[FILT_RED] && scaled[FILT_GREEN] > scaled[FILT_BLUE] &&
                     scaled[FILT_GREEN] > scaled[FILT_CLEAR]) begin
            decision = COLOR_GREEN;
        end else if (scaled[FILT_BLUE] > scaled[FILT_RED] && scaled[FILT_BLUE] > scaled[FILT_GREEN] &&
                     scaled[FILT_BLUE] > scaled[FILT_CLEAR]) begin
            decision = COLOR_BLUE;
        end
    end

    // Confirmation counter update and decision to change the reported colour.
    always_comb begin
        cand_next = decision;
        conf_next = CONF_W'(1);
        if (decision == candidate) begin
            cand_next = candidate;
            conf_next = (confirm_cnt == CONF_MAX) ? confirm_cnt : confirm_cnt + 1'b1;
        end
        update = (conf_next == CONF_MAX) && (cand_next != color);
    end

    // Round results; everything visible updates together with raw_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counts        <= '0;
            raw_color     <= COLOR_NONE;
            color         <= COLOR_NONE;
            candidate     <= COLOR_NONE;
            confirm_cnt   <= '0;
            raw_valid     <= 1'b0;
            color_changed <= 1'b0;
        end else begin
            raw_valid     <= 1'b0;
            color_changed <= 1'b0;
            if (state == ST_DECIDE) begin
                counts      <= {chan_cnt[3], chan_cnt[2], chan_cnt[1], chan_cnt[0]};
                raw_color   <= decision;
                raw_valid   <= 1'b1;
                candidate   <= cand_next;
                confirm_cnt <= conf_next;
                if (update) begin
                    color         <= cand_next;
                    color_changed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_classifier.sv
// Bench for color_classifier: short gate/settle windows, a sensor model whose
// period depends on the selected filter, table-driven rounds plus hand-written
// enable-drop, reset, hysteresis and saturation sequences.
module tb_color_classifier;

    localparam int GATE     = 100;
    localparam int SETTLE   = 4;
    localparam int CNT_W    = 8;
    localparam int SAT_W    = 5;
    localparam int GAIN_W   = 6;
    localparam int CONFIRM  = 2;
    localparam int DOM_NONE = 4;
    localparam int ROUND_TO_VALID = 4 * (SETTLE + GATE) + 2;

    typedef struct {
        int dom;
        int green_gain;
        int exp_raw;
        int exp_color;
        int exp_changed;
    } round_vec_t;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic                enable_sat = 1'b0;
    logic                colorsignal = 1'b0;
    logic                colorsignal_sat = 1'b0;
    logic [4*GAIN_W-1:0] gain;

    logic                S0, S1, S2, S3;
    logic [4*CNT_W-1:0]  counts;
    logic                raw_valid;
    logic [2:0]          raw_color;
    logic [2:0]          color;
    logic                color_changed;

    logic                sat_S0, sat_S1, sat_S2, sat_S3;
    logic [4*SAT_W-1:0]  sat_counts;
    logic                sat_raw_valid;
    logic [2:0]          sat_raw_color;
    logic [2:0]          sat_color;
    logic                sat_color_changed;

    int dom = DOM_NONE;
    int cyc = 0;
    int changed_pulses = 0;
    int raw_pulses = 0;
    int checks = 0;
    int errors = 0;

    round_vec_t main_rounds [7];
    round_vec_t hyst_rounds [4];

    color_classifier #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W),
        .GAIN_W(GAIN_W), .CONFIRM(CONFIRM), .SCALE_S0(1'b1), .SCALE_S1(1'b0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .colorsignal(colorsignal),
        .gain(gain), .S0(S0), .S1(S1), .S2(S2), .S3(S3), .counts(counts),
        .raw_valid(raw_valid), .raw_color(raw_color), .color(color),
        .color_changed(color_changed)
    );

    color_classifier #(
        .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(SAT_W),
        .GAIN_W(GAIN_W), .CONFIRM(CONFIRM), .SCALE_S0(1'b1), .SCALE_S1(1'b0)
    ) sat_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable_sat), .colorsignal(colorsignal_sat),
        .gain(gain), .S0(sat_S0), .S1(sat_S1), .S2(sat_S2), .S3(sat_S3), .counts(sat_counts),
        .raw_valid(sat_raw_valid), .raw_color(sat_raw_color), .color(sat_color),
        .color_changed(sat_color_changed)
    );

    always #5 clock = ~clock;

    // Sensor model: period 8 on the dominant filter, 20 elsewhere; the
    // saturation instance sees a period-2 square wave.
    always @(negedge clock) begin
        int filt;
        int period;
        cyc = cyc + 1;
        case ({S2, S3})
            2'b01:   filt = 0;
            2'b11:   filt = 1;
            2'b00:   filt = 2;
            default: filt = 3;
        endcase
        period = (filt == dom) ? 8 : 20;
        colorsignal = ((cyc % period) >= (period / 2));
        colorsignal_sat = ~colorsignal_sat;
    end

    // Pulse monitors.
    always @(negedge clock) begin
        if (color_changed) changed_pulses = changed_pulses + 1;
        if (raw_valid) raw_pulses = raw_pulses + 1;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks = checks + 1;
        if (actual < lo || actual > hi) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic check_counts(input string tag, input int dominant);
        for (int ch = 0; ch < 4; ch++) begin
            int val;
            val = int'(counts[ch*CNT_W +: CNT_W]);
            if (ch == dominant)
                check_range($sformatf("%s count[%0d]", tag, ch), val, 12, 13);
            else
                check_output($sformatf("%s count[%0d]", tag, ch), val, 5);
        end
    endtask

    task automatic wait_raw_valid(input string tag, output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 2000) begin
            @(negedge clock);
            n = n + 1;
            if (raw_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL %s raw_valid timeout: got none, expected a pulse", tag);
        end
    endtask

    task automatic apply_stimulus(input round_vec_t v);
        dom  = v.dom;
        gain = {6'd1, 6'd1, GAIN_W'(v.green_gain), 6'd1};
    endtask

    task automatic run_table_round(input string tag, input round_vec_t v, input bit first);
        int n;
        apply_stimulus(v);
        if (first) enable = 1'b1;
        wait_raw_valid(tag, n);
        check_output({tag, " raw_color"}, int'(raw_color), v.exp_raw);
        check_output({tag, " color"}, int'(color), v.exp_color);
        check_output({tag, " color_changed"}, int'(color_changed), v.exp_changed);
        check_counts(tag, v.dom);
    endtask

    initial begin
        int n;
        int base;
        bit seen;

        main_rounds[0] = '{2, 1, 1, 0, 0};
        main_rounds[1] = '{2, 1, 1, 1, 1};
        main_rounds[2] = '{2, 1, 1, 1, 0};
        main_rounds[3] = '{DOM_NONE, 1, 4, 1, 0};
        main_rounds[4] = '{DOM_NONE, 2, 2, 1, 0};
        main_rounds[5] = '{DOM_NONE, 2, 2, 2, 1};
        main_rounds[6] = '{0, 1, 3, 2, 0};

        hyst_rounds[0] = '{2, 1, 1, 0, 0};
        hyst_rounds[1] = '{0, 1, 3, 0, 0};
        hyst_rounds[2] = '{2, 1, 1, 0, 0};
        hyst_rounds[3] = '{2, 1, 1, 1, 1};

        gain = {6'd1, 6'd1, 6'd1, 6'd1};
        repeat (3) @(negedge clock);

        check_output("reset counts", int'(counts), 0);
        check_output("reset raw_color", int'(raw_color), 0);
        check_output("reset color", int'(color), 0);
        check_output("reset raw_valid", int'(raw_valid), 0);
        check_output("reset color_changed", int'(color_changed), 0);
        check_output("reset S0", int'(S0), 1);
        check_output("reset S1", int'(S1), 0);
        check_output("reset S2", int'(S2), 0);
        check_output("reset S3", int'(S3), 1);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_table_round($sformatf("round%0d", i), main_rounds[i], i == 0);
        end

        $display("[TB] enable drop during green gate");
        dom = 2;
        gain = {6'd1, 6'd1, 6'd1, 6'd1};
        seen = 1'b0;
        n = 0;
        while (!seen && n < 500) begin
            @(negedge clock);
            n = n + 1;
            if (S2 && S3) seen = 1'b1;
        end
        check_output("green filter reached", int'(seen), 1);
        repeat (30) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check_output("drop S2", int'(S2), 0);
        check_output("drop S3", int'(S3), 1);
        base = raw_pulses;
        repeat (500) @(negedge clock);
        check_output("drop raw_valid pulses", raw_pulses - base, 0);
        check_counts("drop held", 0);
        check_output("drop raw_color held", int'(raw_color), 3);
        check_output("drop color held", int'(color), 2);

        enable = 1'b1;
        wait_raw_valid("restart", n);
        check_output("restart round length", n, ROUND_TO_VALID);
        check_output("restart raw_color", int'(raw_color), 1);
        check_output("restart color", int'(color), 2);
        check_counts("restart", 2);

        $display("[TB] asynchronous reset mid-round");
        repeat (200) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_output("async S2", int'(S2), 0);
        check_output("async S3", int'(S3), 1);
        check_output("async counts", int'(counts), 0);
        check_output("async raw_color", int'(raw_color), 0);
        check_output("async color", int'(color), 0);
        check_output("async raw_valid", int'(raw_valid), 0);
        check_output("async color_changed", int'(color_changed), 0);
        check_output("async S0", int'(S0), 1);
        enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] confirmation hysteresis");
        base = changed_pulses;
        for (int i = 0; i < 4; i++) begin
            run_table_round($sformatf("hyst%0d", i), hyst_rounds[i], i == 0);
        end
        @(negedge clock);
        check_output("hyst changed pulses", changed_pulses - base, 1);
        enable = 1'b0;

        $display("[TB] counter saturation");
        enable_sat = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 2000) begin
            @(negedge clock);
            n = n + 1;
            if (sat_raw_valid) seen = 1'b1;
        end
        check_output("sat raw_valid seen", int'(seen), 1);
        for (int ch = 0; ch < 4; ch++) begin
            check_output($sformatf("sat count[%0d]", ch), int'(sat_counts[ch*SAT_W +: SAT_W]), 31);
        end
        check_output("sat raw_color", int'(sat_raw_color), 4);
        enable_sat = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
